// File: rtl/adder_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_chk_pkg
//  Purpose  : Shared types and default configuration for the 4-bit adder
//             response checker (FSM state encoding, default widths/counts).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package adder_chk_pkg;

  // Default configuration of the checker.
  localparam int C_WIDTH    = 4;  // operand width of i0/i1/o
  localparam int C_NUM_VECS = 8;  // vectors checked per run
  localparam int C_CNT_W    = 4;  // counter width, 2**C_CNT_W > C_NUM_VECS

  // Checker FSM state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : adder_chk_pkg
`default_nettype wire

// File: rtl/adder_ref_model.sv
`default_nettype none
// ============================================================================
//  Module   : adder_ref_model
//  Purpose  : Combinational reference adder, {c,s} = a + b + ci, producing the
//             full WIDTH+1-bit result (carry kept, no truncation).
//  Ports    : a   [WIDTH-1:0] in   operand A
//             b   [WIDTH-1:0] in   operand B
//             ci  1           in   carry-in
//             sum [WIDTH:0]   out  {carry, sum}
//  Revision : 1.0  initial release
// ============================================================================
module adder_ref_model
  import adder_chk_pkg::*;
#(
  parameter int WIDTH = C_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH:0]   sum
);

  // Zero-extend every term to WIDTH+1 bits so the carry-out survives.
  assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

endmodule : adder_ref_model
`default_nettype wire

// File: rtl/adder_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module   : adder_resp_checker
//  Purpose  : Response-side checker for an adder under test. Accepts stimulus
//             vectors {i0,i1,cin} on a valid/ready handshake, computes the
//             reference sum, and one cycle later compares {cout,o} from the
//             adder against it. Keeps pass/fail tallies, a sticky error flag
//             and asserts done after NUM_VECS vectors.
//  Ports    : clk        in   rising-edge clock
//             reset      in   synchronous active-low reset
//             clr        in   synchronous run restart
//             vec_valid  in   stimulus vector present
//             vec_ready  out  checker can accept a vector
//             i0, i1     in   operands of offered vector [WIDTH]
//             cin        in   carry-in of offered vector
//             o, cout    in   result returned by adder under test
//             pass_cnt   out  matching vectors [CNT_W]
//             fail_cnt   out  mismatching vectors [CNT_W]
//             err        out  sticky mismatch flag for this run
//             done       out  NUM_VECS vectors checked
//             fail_idx   out  index of first failing vector [CNT_W]
//  Config   : FIRST_FAIL_LOG_EN - when defined, fail_idx latches the index of
//             the first mismatching vector of a run; otherwise it is tied 0.
//  Revision : 1.0  initial release
// ============================================================================
module adder_resp_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH    = C_WIDTH,
  parameter int NUM_VECS = C_NUM_VECS,
  parameter int CNT_W    = C_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             cin,
  input  logic [WIDTH-1:0] o,
  input  logic             cout,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic             done,
  output logic [CNT_W-1:0] fail_idx
);

  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_VECS - 1);

  state_t           r_state;
  logic [WIDTH:0]   r_exp;
  logic [CNT_W-1:0] r_vec_idx;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_err;
  logic             r_done;
  logic             r_vec_ready;

  logic [WIDTH:0]   w_sum;
  logic             w_mismatch;
  logic             w_restart;

  adder_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref (
    .a   (i0),
    .b   (i1),
    .ci  (cin),
    .sum (w_sum)
  );

  // Case-inequality so an X/Z on the adder outputs is a mismatch rather
  // than silently comparing as equal.
  assign w_mismatch = ({cout, o} !== r_exp);

  // Reset and clr share one restart path; reset is listed first only for
  // readability, both return every register to its run-start value.
  assign w_restart = !reset || clr;

  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_state     <= IDLE;
      r_exp       <= '0;
      r_vec_idx   <= '0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_vec_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          // vec_ready is high throughout IDLE, so valid alone is the accept.
          if (vec_valid) begin
            r_exp       <= w_sum;
            r_state     <= CHECK;
            r_vec_ready <= 1'b0;
          end
        end

        CHECK: begin
          if (w_mismatch) begin
            r_fail_cnt <= r_fail_cnt + C_ONE;
            r_err      <= 1'b1;
          end else begin
            r_pass_cnt <= r_pass_cnt + C_ONE;
          end
          r_vec_idx <= r_vec_idx + C_ONE;
          // Compare against the pre-increment index: this check completes
          // vector number NUM_VECS.
          if (r_vec_idx == C_LAST) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state     <= IDLE;
            r_vec_ready <= 1'b1;
          end
        end

        DONE: begin
          // Parked until clr/reset; any offered vector is ignored.
          r_state     <= DONE;
          r_done      <= 1'b1;
          r_vec_ready <= 1'b0;
        end

        default: begin
          r_state     <= IDLE;
          r_vec_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef FIRST_FAIL_LOG_EN
  logic [CNT_W-1:0] r_fail_idx;

  // Latch only while err is still clear, i.e. on the first mismatch of a run.
  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_fail_idx <= '0;
    end else if ((r_state == CHECK) && w_mismatch && !r_err) begin
      r_fail_idx <= r_vec_idx;
    end
  end

  assign fail_idx = r_fail_idx;
`else
  assign fail_idx = '0;
`endif

  assign vec_ready = r_vec_ready;
  assign pass_cnt  = r_pass_cnt;
  assign fail_cnt  = r_fail_cnt;
  assign err       = r_err;
  assign done      = r_done;

endmodule : adder_resp_checker
`default_nettype wire
